// File: rtl/rf_path_sequencer_if.sv
// IOC register bus between the command decoder (master) and the RF path sequencer (slave).
interface rf_path_sequencer_if;
    logic [4:0] i_ioc;
    logic [7:0] i_data_in;
    logic [7:0] o_data_out;
    logic       i_cs;
    logic       i_fetch_cmd;
    logic       i_load_cmd;

    modport master (
        output i_ioc, i_data_in, i_cs, i_fetch_cmd, i_load_cmd,
        input  o_data_out
    );

    modport slave (
        input  i_ioc, i_data_in, i_cs, i_fetch_cmd, i_load_cmd,
        output o_data_out
    );
endinterface

// File: rtl/rf_path_sequencer.sv
// Multi-channel RF front-end pin controller: register file on the IOC bus plus one
// break-before-make sequencer per channel (amps off, switches move, amps on).
module rf_path_channel #(
    parameter int GUARD_CYC  = 16,
    parameter int SETTLE_CYC = 64
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_wr,       // MODE write accepted this cycle
    input  logic       i_wr_dbg,   // that write selects debug
    input  logic [7:0] i_wr_vec,   // resolved target vector of that write
    input  logic       i_dbg,      // stored MODE selects debug
    input  logic [7:0] i_pin,
    output logic [7:0] o_pins,
    output logic       o_busy
);
    localparam int MAXC = (GUARD_CYC > SETTLE_CYC) ? GUARD_CYC : SETTLE_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [7:0] SAFE = 8'h56;

    typedef enum logic [1:0] {ST_RUN, ST_BREAK, ST_SWITCH} state_e;

    state_e        state_q, state_d;
    logic [7:0]    cur_q, cur_d, tgt_q, tgt_d, pins_q, pins_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          dbg_eff;

    // A debug write takes effect on the same edge it is accepted.
    assign dbg_eff = i_wr ? i_wr_dbg : i_dbg;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        if (dbg_eff) begin
            state_d = ST_RUN;
            cur_d   = i_pin;
            tgt_d   = i_pin;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (i_wr && i_wr_vec != cur_q) begin
                        tgt_d   = i_wr_vec;
                        state_d = ST_BREAK;
                        cnt_d   = CW'(GUARD_CYC - 1);
                    end
                end
                ST_BREAK, ST_SWITCH: begin
                    if (i_wr && i_wr_vec != tgt_q) begin
                        // Freeze the switches where they are now; amps stay off.
                        tgt_d      = i_wr_vec;
                        cur_d[7:3] = (state_q == ST_SWITCH) ? tgt_q[7:3] : cur_q[7:3];
                        state_d    = ST_BREAK;
                        cnt_d      = CW'(GUARD_CYC - 1);
                    end else if (cnt_q == '0) begin
                        if (state_q == ST_BREAK) begin
                            state_d = ST_SWITCH;
                            cnt_d   = CW'(SETTLE_CYC - 1);
                        end else begin
                            cur_d   = tgt_q;
                            state_d = ST_RUN;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        case (state_d)
            ST_BREAK:  pins_d = {cur_d[7:3], 3'b110};
            ST_SWITCH: pins_d = {tgt_d[7:3], 3'b110};
            default:   pins_d = cur_d;
        endcase
        busy_d = (state_d != ST_RUN);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_RUN;
            cur_q   <= SAFE;
            tgt_q   <= SAFE;
            cnt_q   <= '0;
            pins_q  <= SAFE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            pins_q  <= pins_d;
            busy_q  <= busy_d;
        end
    end

    assign o_pins = pins_q;
    assign o_busy = busy_q;
endmodule

module rf_path_sequencer #(
    parameter int         NUM_CH     = 1,
    parameter int         GUARD_CYC  = 16,
    parameter int         SETTLE_CYC = 64,
    parameter logic [7:0] VERSION    = 8'h02
) (
    input  logic                  i_sys_clk,
    input  logic                  i_rst,
    rf_path_sequencer_if.slave    bus,
    output logic [8*NUM_CH-1:0]   o_rf_pins,
    output logic [NUM_CH-1:0]     o_busy
);
    function automatic logic [7:0] mode_vec(input logic [2:0] m);
        case (m)
            3'd1:    return 8'h26;
            3'd2:    return 8'h89;
            3'd3:    return 8'h59;
            3'd4:    return 8'h6B;
            3'd5:    return 8'hAB;
            default: return 8'h56;
        endcase
    endfunction

    logic [NUM_CH-1:0][4:0] mode_q, mode_d;
    logic [NUM_CH-1:0][7:0] pin_q, pin_d, pins;
    logic [NUM_CH-1:0]      mode_wr;
    logic [7:0]             data_out_q, data_out_d, rd_data;
    logic                   err_q, err_d;
    logic                   fetch, load;
    logic [3:0]             busy_ext;

    // A fetch in the same cycle as a load wins; the load is dropped.
    assign fetch = bus.i_cs & bus.i_fetch_cmd;
    assign load  = bus.i_cs & bus.i_load_cmd & ~bus.i_fetch_cmd;

    always_comb begin
        busy_ext = '0;
        busy_ext[NUM_CH-1:0] = o_busy;
        mode_d  = mode_q;
        pin_d   = pin_q;
        mode_wr = '0;
        err_d   = err_q;
        rd_data = '0;
        if (load && bus.i_ioc == 5'h01 && bus.i_data_in[7])
            err_d = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (load && bus.i_ioc == 5'(8 + c)) begin
                mode_wr[c] = 1'b1;
                mode_d[c]  = bus.i_data_in[4:0];
                if (bus.i_data_in[4:3] == 2'b11)
                    err_d = 1'b1;
            end
            if (load && bus.i_ioc == 5'(16 + c))
                pin_d[c] = bus.i_data_in;
            if (bus.i_ioc == 5'(8 + c))
                rd_data = {3'b000, mode_q[c]};
            if (bus.i_ioc == 5'(16 + c))
                rd_data = pin_q[c];
        end
        if (bus.i_ioc == 5'h00)
            rd_data = VERSION;
        if (bus.i_ioc == 5'h01)
            rd_data = {err_q, 3'b000, busy_ext};
        data_out_d = fetch ? rd_data : data_out_q;
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            mode_q     <= '0;
            pin_q      <= '0;
            err_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            mode_q     <= mode_d;
            pin_q      <= pin_d;
            err_q      <= err_d;
            data_out_q <= data_out_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        rf_path_channel #(
            .GUARD_CYC  (GUARD_CYC),
            .SETTLE_CYC (SETTLE_CYC)
        ) u_ch (
            .i_clk    (i_sys_clk),
            .i_rst    (i_rst),
            .i_wr     (mode_wr[c]),
            .i_wr_dbg (bus.i_data_in[1:0] == 2'b01),
            .i_wr_vec (mode_vec(bus.i_data_in[4:2])),
            .i_dbg    (mode_q[c][1:0] == 2'b01),
            .i_pin    (pin_q[c]),
            .o_pins   (pins[c]),
            .o_busy   (o_busy[c])
        );
    end

    assign o_rf_pins      = pins;
    assign bus.o_data_out = data_out_q;
endmodule

// File: tb/tb_rf_path_sequencer.sv
// Directed bench for rf_path_sequencer: two channels, short guard/settle times.
module tb_rf_path_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rf_pins;
    logic [1:0]  busy;
    logic [7:0]  rd;
    int          n_vec  = 0;
    int          n_miss = 0;

    rf_path_sequencer_if bus ();

    rf_path_sequencer #(
        .NUM_CH     (2),
        .GUARD_CYC  (4),
        .SETTLE_CYC (8),
        .VERSION    (8'h02)
    ) dut (
        .i_sys_clk (clk),
        .i_rst     (rst),
        .bus       (bus),
        .o_rf_pins (rf_pins),
        .o_busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.i_cs = 1'b1; bus.i_load_cmd = 1'b1; bus.i_ioc = a; bus.i_data_in = d;
        @(posedge clk); #1;
        bus.i_cs = 1'b0; bus.i_load_cmd = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.i_cs = 1'b1; bus.i_fetch_cmd = 1'b1; bus.i_ioc = a;
        @(posedge clk); #1;
        bus.i_cs = 1'b0; bus.i_fetch_cmd = 1'b0;
        d = bus.o_data_out;
    endtask

    initial begin
        rst = 1'b1;
        bus.i_cs = 1'b0; bus.i_fetch_cmd = 1'b0; bus.i_load_cmd = 1'b0;
        bus.i_ioc = '0; bus.i_data_in = '0;

        // 1. reset state
        tick(2);
        rst = 1'b0;
        chk("rst_pins", rf_pins, 16'h5656);
        chk("rst_busy", busy, 2'b00);
        chk("rst_dout", bus.o_data_out, 8'h00);
        bus_read(5'h00, rd); chk("version", rd, 8'h02);
        bus_read(5'h01, rd); chk("status_rst", rd, 8'h00);

        // 2. ch0 SAFE -> rx_lpf: 4 cycles BREAK, 8 cycles SWITCH, then target
        bus_write(5'h08, 8'h08);
        for (int k = 1; k <= 14; k++) begin
            chk($sformatf("seq2_pin%0d", k), rf_pins[7:0],
                (k <= 4) ? 8'h56 : (k <= 12) ? 8'h8E : 8'h89);
            chk($sformatf("seq2_bsy%0d", k), busy, (k <= 12) ? 2'b01 : 2'b00);
            tick(1);
        end
        chk("seq2_ch1", rf_pins[15:8], 8'h56);

        // 3. ch0 rx_lpf -> tx_hpf, redirected to rx_hpf mid-SWITCH
        bus_write(5'h08, 8'h14);
        chk("seq3_brk", rf_pins[7:0], 8'h8E);
        tick(4);
        chk("seq3_sw", rf_pins[7:0], 8'hAE);
        bus_read(5'h01, rd); chk("seq3_status", rd, 8'h01);
        chk("seq3_sw2", rf_pins[7:0], 8'hAE);
        bus_write(5'h08, 8'h0C);
        for (int k = 1; k <= 13; k++) begin
            chk($sformatf("seq3_pin%0d", k), rf_pins[7:0],
                (k <= 4) ? 8'hAE : (k <= 12) ? 8'h5E : 8'h59);
            tick(1);
        end
        chk("seq3_idle", busy, 2'b00);

        // 4. illegal mode on ch1, sticky ERR with write-1-to-clear
        bus_write(5'h09, 8'h18);
        chk("err_pins", rf_pins[15:8], 8'h56);
        chk("err_busy", busy, 2'b00);
        bus_read(5'h01, rd); chk("err_set", rd, 8'h80);
        bus_write(5'h01, 8'h00);
        bus_read(5'h01, rd); chk("err_w0", rd, 8'h80);
        bus_write(5'h01, 8'h80);
        bus_read(5'h01, rd); chk("err_clr", rd, 8'h00);

        // 5. debug pins on ch1, fetch+load collision, unmapped addresses
        bus_write(5'h11, 8'hA5);
        bus_read(5'h11, rd); chk("pin_rd", rd, 8'hA5);
        bus_write(5'h09, 8'h01);
        chk("dbg_pins", rf_pins[15:8], 8'hA5);
        chk("dbg_busy", busy, 2'b00);
        bus_write(5'h11, 8'h3C);
        chk("dbg_lag", rf_pins[15:8], 8'hA5);
        tick(1);
        chk("dbg_follow", rf_pins[15:8], 8'h3C);
        @(negedge clk);
        bus.i_cs = 1'b1; bus.i_fetch_cmd = 1'b1; bus.i_load_cmd = 1'b1;
        bus.i_ioc = 5'h11; bus.i_data_in = 8'hFF;
        @(posedge clk); #1;
        bus.i_cs = 1'b0; bus.i_fetch_cmd = 1'b0; bus.i_load_cmd = 1'b0;
        chk("coll_dout", bus.o_data_out, 8'h3C);
        bus_read(5'h11, rd); chk("coll_pin", rd, 8'h3C);
        chk("coll_pins", rf_pins[15:8], 8'h3C);
        bus_read(5'h09, rd); chk("mode_rd", rd, 8'h01);
        tick(3);
        chk("dout_hold", bus.o_data_out, 8'h01);
        bus_read(5'h0A, rd); chk("unmap_mode", rd, 8'h00);
        bus_write(5'h12, 8'h77);
        bus_read(5'h12, rd); chk("unmap_pin", rd, 8'h00);
        bus_read(5'h1F, rd); chk("unmap_hi", rd, 8'h00);

        // 6. reset while ch1 is in BREAK and ch0 sits at rx_lpf
        bus_write(5'h08, 8'h08);
        tick(12);
        chk("pre_rst_ch0", rf_pins[7:0], 8'h89);
        bus_write(5'h09, 8'h08);
        chk("pre_rst_ch1", rf_pins[15:8], 8'h3E);
        chk("pre_rst_bsy", busy, 2'b10);
        tick(1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_pins", rf_pins, 16'h5656);
        chk("mid_rst_busy", busy, 2'b00);
        chk("mid_rst_dout", bus.o_data_out, 8'h00);
        rst = 1'b0;
        bus_read(5'h09, rd); chk("post_rst_mode", rd, 8'h00);
        bus_read(5'h11, rd); chk("post_rst_pin", rd, 8'h00);
        tick(20);
        chk("post_rst_pins", rf_pins, 16'h5656);
        chk("post_rst_busy", busy, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
